// File: rtl/weight_stream_locator_if.sv
// Word-in / set-bit-index-out stream bundle for weight_stream_locator.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the word side, out_valid/out_ready on the index side.
interface weight_stream_locator_if #(
  parameter int W  = 8,
  parameter int IW = $clog2(W),
  parameter int CW = $clog2(W + 1)
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_msb_first;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          out_empty;
  logic [CW-1:0] out_count;

  // Word source / beat consumer side
  modport master (
    output in_valid, in_data, in_msb_first, out_ready,
    input  in_ready, out_valid, out_index, out_last, out_empty, out_count
  );

  // Locator side
  modport slave (
    input  in_valid, in_data, in_msb_first, out_ready,
    output in_ready, out_valid, out_index, out_last, out_empty, out_count
  );
endinterface

// File: rtl/weight_stream_locator.sv
// Streams the bit index of every set bit of a W-bit word, LSB-first or MSB-first, with popcount.
// Latency: first beat one cycle after accept; one beat per cycle; max(popcount,1)+1 cycles per word.
// Backpressure: out_ready stalls the stream with outputs held; in_ready is low for the whole word.
module weight_stream_locator #(
  parameter int W  = 8,
  parameter int IW = $clog2(W),
  parameter int CW = $clog2(W + 1)
) (
  input logic                    clk,
  input logic                    rst_n,
  weight_stream_locator_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  residual;   // set bits not yet emitted
  logic          order;      // 1 = highest index first
  logic [CW-1:0] count;      // popcount of the word in flight
  logic [CW-1:0] in_pop;
  logic [IW-1:0] lo_idx;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] sel_idx;
  logic          res_zero;
  logic          res_single;

  // Popcount of the incoming word, captured at accept so it stays constant across beats
  always_comb begin
    in_pop = '0;
    for (int i = 0; i < W; i++) begin
      in_pop = in_pop + CW'(bus.in_data[i]);
    end
  end

  // Lowest and highest set bit of the residual; both are 0 for an empty residual
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (residual[i]) lo_idx = IW'(i);
    end
    for (int i = 0; i < W; i++) begin
      if (residual[i]) hi_idx = IW'(i);
    end
  end

  assign sel_idx    = order ? hi_idx : lo_idx;
  assign res_zero   = (residual == '0);
  // Clearing the lowest set bit leaves zero exactly when one bit remains
  assign res_single = !res_zero && ((residual & (residual - ONE)) == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs; outputs depend only on registered state
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_index = '0;
    bus.out_last  = 1'b0;
    bus.out_empty = 1'b0;
    bus.out_count = '0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = EMIT;
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_index = sel_idx;
        bus.out_empty = res_zero;
        bus.out_last  = res_zero | res_single;
        bus.out_count = count;
        if (bus.out_ready && (res_zero || res_single)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the word on accept, then strip one bit per accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      residual <= '0;
      order    <= 1'b0;
      count    <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      residual <= bus.in_data;
      order    <= bus.in_msb_first;
      count    <= in_pop;
    end else if (state == EMIT && bus.out_ready) begin
      residual <= residual & ~(ONE << sel_idx);
    end
  end

endmodule

// File: tb/tb_weight_stream_locator.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus pushes expected beats from a list-based model, a monitor pops on transfers.
module tb_weight_stream_locator;
  localparam int W  = 8;
  localparam int IW = $clog2(W);
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  weight_stream_locator_if #(.W(W)) bus ();

  weight_stream_locator #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit last;
    bit empty;
    int cnt;
  } beat_t;

  beat_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int beats_seen = 0;
  int mode = 0;      // 0: out_ready high, 1: 1,0,0 pattern, 2: random
  int pc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: list the set-bit positions, reverse for MSB-first
  task automatic push_expected(input logic [W-1:0] w, input logic msb);
    int pos[$];
    beat_t b;
    for (int i = 0; i < W; i++) if (w[i]) pos.push_back(i);
    if (msb) pos.reverse();
    if (pos.size() == 0) begin
      b.idx = 0; b.last = 1; b.empty = 1; b.cnt = 0;
      exp_q.push_back(b);
    end else begin
      foreach (pos[k]) begin
        b.idx = pos[k]; b.last = (k == pos.size() - 1); b.empty = 0; b.cnt = pos.size();
        exp_q.push_back(b);
      end
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accepting edge
  task automatic send_word(input logic [W-1:0] w, input logic msb);
    int n = 0;
    while (!bus.in_ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    end else begin
      push_expected(w, msb);
      bus.in_valid = 1'b1; bus.in_data = w; bus.in_msb_first = msb;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_msb_first = 1'b0;
    end
  endtask

  // With out_ready held high: n back-to-back beats, then idle
  task automatic expect_burst(input int n);
    for (int k = 0; k < n; k++) begin
      chk("burst_out_valid", 64'(bus.out_valid), 64'd1);
      chk("burst_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    chk("after_burst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("after_burst_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!bus.in_ready || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Consumer ready driver
  always @(posedge clk) begin
    #2;
    case (mode)
      0: bus.out_ready = 1'b1;
      1: begin bus.out_ready = (pc == 0); pc = (pc + 1) % 3; end
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: hold check on stalls, scoreboard compare on transfers
  logic          stall_prev = 1'b0;
  logic [IW-1:0] p_index;
  logic          p_last, p_empty;
  logic [CW-1:0] p_count;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_fields", 64'({bus.out_index, bus.out_last, bus.out_empty, bus.out_count}),
            64'({p_index, p_last, p_empty, p_count}));
      end
      if (bus.out_valid) chk("in_ready_low_while_emit", 64'(bus.in_ready), 64'd0);
      if (bus.out_valid && bus.out_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(bus.out_index), 64'hDEAD);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_index", 64'(bus.out_index), 64'(e.idx));
          chk("out_last", 64'(bus.out_last), 64'(e.last));
          chk("out_empty", 64'(bus.out_empty), 64'(e.empty));
          chk("out_count", 64'(bus.out_count), 64'(e.cnt));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      p_index = bus.out_index; p_last = bus.out_last;
      p_empty = bus.out_empty; p_count = bus.out_count;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected < 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int nwords;
    logic [63:0] r;
    logic [W-1:0] w;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_msb_first = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    #3;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_fields", 64'({bus.out_index, bus.out_last, bus.out_empty, bus.out_count}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

    // 1010_0110 ascending then descending, back-to-back timing
    mode = 0;
    send_word(W'(8'hA6), 1'b0);
    expect_burst(4);
    send_word(W'(8'hA6), 1'b1);
    expect_burst(4);

    // Zero word: single empty beat
    send_word(W'(8'h00), 1'b0);
    expect_burst(1);

    // All ones under 1,0,0 backpressure
    @(posedge clk); #1;
    mode = 1; pc = 0;
    base = beats_seen;
    send_word(W'(8'hFF), 1'b0);
    wait_idle();
    chk("ff_beat_count", 64'(beats_seen - base), 64'd8);
    mode = 0;
    @(posedge clk); #1;

    // Reset after the second beat of F0
    base = beats_seen;
    send_word(W'(8'hF0), 1'b0);
    n = 0;
    while (beats_seen < base + 2 && n < 50) begin @(negedge clk); n++; end
    chk("f0_two_beats", 64'(beats_seen - base), 64'd2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midreset_out_fields", 64'({bus.out_index, bus.out_last, bus.out_empty, bus.out_count}), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = beats_seen;
    repeat (3) @(posedge clk);
    #1;
    chk("no_beats_after_reset", 64'(beats_seen - base), 64'd0);
    chk("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    send_word(W'(8'h01), 1'b0);
    expect_burst(1);

    // Sweep (exhaustive for small W, random otherwise) in both orders with random out_ready
    mode = 2;
    nwords = (W <= 8) ? (1 << W) : 400;
    for (int o = 0; o < 2; o++) begin
      for (int v = 0; v < nwords; v++) begin
        r = {$urandom, $urandom};
        w = (W <= 8) ? W'(v) : W'(r);
        send_word(w, 1'(o));
      end
    end
    wait_idle();
    mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/weight_stream_locator.md
# weight_stream_locator

Sequential, parametrised successor to the combinational weight locator. It accepts one W-bit word per handshake and computes its popcount. It then streams the bit index of every set bit, one index per beat, in LSB-first or MSB-first order, over a valid/ready output with a last flag. It sits between a word source and any consumer that processes set-bit positions serially, and replaces the fixed 8-output locator fan-out with a width-independent stream.

## Interface
- W, default 8: input word width; legal range 2..64.
- IW, default $clog2(W): index width (derived; do not override).
- CW, default $clog2(W+1): popcount width (derived; do not override).
- clk  input  1  system clock; all state is updated on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  in_data and in_msb_first are valid.
- in_ready  output  1  block can accept a word.
- in_data  input  W  word to locate.
- in_msb_first  input  1  order select: 0 = ascending indices, 1 = descending indices; captured with the word.
- out_valid  output  1  output beat is valid.
- out_ready  input  1  consumer accepts the beat.
- out_index  output  IW  bit position of the current set bit.
- out_last  output  1  final beat of the current word.
- out_empty  output  1  word had no set bits; this is the single beat for that word.
- out_count  output  CW  popcount of the current word; constant for all beats of the word.

## Operation
- Two states: IDLE and EMIT.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid&in_ready: residual <= in_data; order <= in_msb_first; out_count <= popcount(in_data); go to EMIT.
- EMIT: in_ready=0, out_valid=1.
  - If residual != 0:
    - out_index = lowest set bit of residual when order=0, highest set bit when order=1.
    - out_empty=0.
    - out_last=1 when residual has exactly one set bit.
  - If residual == 0 (only possible for a zero input word): out_index=0, out_empty=1, out_last=1, out_count=0.
  - On out_valid&out_ready:
    - Clear the bit at out_index in residual.
    - If out_last=1, go to IDLE.
- Beat count per word: max(popcount, 1). Indices are strictly monotonic in the selected order, and each index is emitted exactly once.
- Hold rule: while out_valid&!out_ready, out_index, out_last, out_empty and out_count are stable.
- Inputs during EMIT are ignored; in_data is not buffered.
- Popcount and priority select are combinational over W bits. No truncation: out_count reaches W for an all-ones word (CW bits suffice).

## Timing
- Reset (async assert, synchronous deassert by the environment) gives:
  - state=IDLE, residual=0, order=0.
  - out_valid=0, out_index=0, out_last=0, out_empty=0, out_count=0.
  - in_ready=1 from the first cycle after reset release.
- Latency: the first output beat is valid in the cycle after input acceptance (1 clk).
- With out_ready held high, beats are back-to-back, one per cycle.
- in_ready returns high in the cycle after the last beat is accepted.
- Throughput: max(popcount, 1) + 1 cycles per word. No same-cycle overlap between the last beat and the next input accept.
- Reset mid-word: the block drops the partial word immediately (async), returns to IDLE, and emits no further beats for that word.
- out_ready may be asserted before out_valid. A beat transfers only on out_valid&out_ready.
- Outputs are registered or derived only from registered state. There is no combinational path from in_* or out_ready to out_*.

## Test plan
- W=8, 8'b1010_0110, in_msb_first=0, out_ready=1:
  - Accept at cycle t. Beats at t+1..t+4 carry indices 1,2,5,7.
  - out_count=4 on every beat; out_last only with index 7.
  - in_ready=1 at t+5.
- Same word, in_msb_first=1: indices 7,5,2,1, with out_last on index 1.
- 8'h00: exactly one beat with out_empty=1, out_last=1, out_index=0, out_count=0. Return to IDLE in the following cycle.
- 8'hFF with out_ready toggling 1,0,0,1,...:
  - 8 beats carrying indices 0..7 in order, with out_count=8.
  - Outputs are held stable on every stall cycle.
  - in_ready stays 0 until the last beat is accepted.
- rst_n pulsed low after the second beat of 8'hF0:
  - out_valid drops asynchronously and all outputs return to their reset values.
  - After release, word 8'h01 yields a single beat with index 0, out_last=1, out_count=1.
- Exhaustive sweep of 0..255 in both orders with random out_ready: a scoreboard checks the index set, the order, out_count, and out_last against a software popcount/locate model. Repeat the build with W=16 using randomised words.
